scan_row_rx: RTL and testbench



---
 rtl/scan_pkg.sv | 29 ++
 rtl/scan_rx_sync.sv | 30 +++
 rtl/scan_row_rx.sv | 252 +++++++++++++++++++++++++
 tb/tb_scan_row_rx.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// scan_pkg: shared widths, FSM encoding and strobe timing for the scan row-driver link.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package scan_pkg;

    // Default geometry of the row-driver link
    localparam int SCAN_ROW_W      = 10;
    localparam int SCAN_NUM_ROWS   = 1024;
    localparam int SCAN_STROBE_LEN = 3;

    // Strobe timing shared by transmitter and receiver so both sides agree
    localparam int SCAN_LRN_LEAD    = 1;   // samples of lrn=0 before the first data bit
    localparam int SCAN_G2_LEN      = 1;   // samples g2 is held high per row
    localparam int SCAN_SYNC_STAGES = 2;   // extra receiver latency with the input synchronizer

    // Receiver FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        LATCHED = 2'd2,
        WRITE   = 2'd3
    } scan_state_t;

    // Next expected row address, wrapping at the end of the pass
    function automatic int unsigned next_row(input int unsigned cur, input int unsigned num_rows);
        return (cur + 1 >= num_rows) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/scan_rx_sync.sv
// scan_rx_sync: N-bit two-flop synchronizer bank for asynchronous panel inputs.
// Latency: 2 cycles.
// Backpressure: none; every input bit is resampled each cycle.
module scan_rx_sync #(
    parameter int             N       = 8,
    parameter logic [N-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i_dat,
    output logic [N-1:0] o_dat
);

    logic [N-1:0] r_meta;
    logic [N-1:0] r_sync;

    // Two back-to-back flops; reset values chosen so idle lines look inactive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_dat;
            r_sync <= r_meta;
        end
    end

    assign o_dat = r_sync;

endmodule

// File: rtl/scan_row_rx.sv
// scan_row_rx: receiver/checker for the scan-panel row-driver serial interface.
// Latency: all outputs registered, 1 cycle after the deciding sample (+2 with SCAN_RX_SYNC_EN).
// Backpressure: none; the link is free-running and every sample is consumed.
// Build option: SCAN_RX_SYNC_EN inserts a 2-flop synchronizer on all eight inputs.
module scan_row_rx
    import scan_pkg::*;
#(
    parameter int ROW_W      = SCAN_ROW_W,
    parameter int NUM_ROWS   = SCAN_NUM_ROWS,
    parameter int STROBE_LEN = SCAN_STROBE_LEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lrn,
    input  logic             g2,
    input  logic             ren,
    input  logic             woe,
    input  logic             g1,
    input  logic             col_start,
    input  logic             col_shift,
    input  logic             row_data,
    output logic [ROW_W-1:0] row_addr,
    output logic             row_addr_vld,
    output logic             row_wr_en,
    output logic [ROW_W:0]   row_cnt,
    output logic             clr_done,
    output logic             clr_ok,
    output logic             err_proto,
    output logic             err_seq,
    output logic             err_len
);

    localparam int SMP_W = $clog2(ROW_W + 1);
    localparam int STB_W = $clog2(STROBE_LEN + 2);

    localparam logic [SMP_W-1:0] SMP_MAX = SMP_W'(ROW_W);
    localparam logic [STB_W-1:0] STB_REQ = STB_W'(STROBE_LEN);
    localparam logic [STB_W-1:0] STB_MAX = STB_W'(STROBE_LEN + 1);
    localparam logic [ROW_W:0]   CNT_MAX = (ROW_W + 1)'(NUM_ROWS);

    // Sampled view of the link
    logic w_lrn, w_g2, w_ren, w_woe, w_g1, w_col_start, w_col_shift, w_row_data;

`ifdef SCAN_RX_SYNC_EN
    logic [7:0] w_sync_out;

    // lrn resets high so the synchronizer does not fake a pass start
    scan_rx_sync #(
        .N       (8),
        .RST_VAL (8'h80)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_dat ({lrn, g2, ren, woe, g1, col_start, col_shift, row_data}),
        .o_dat (w_sync_out)
    );

    assign {w_lrn, w_g2, w_ren, w_woe, w_g1, w_col_start, w_col_shift, w_row_data} = w_sync_out;
`else
    assign w_lrn       = lrn;
    assign w_g2        = g2;
    assign w_ren       = ren;
    assign w_woe       = woe;
    assign w_g1        = g1;
    assign w_col_start = col_start;
    assign w_col_shift = col_shift;
    assign w_row_data  = row_data;
`endif

    scan_state_t      r_state;
    logic [ROW_W-1:0] r_shift;
    logic [SMP_W-1:0] r_smp_cnt;
    logic [STB_W-1:0] r_stb_cnt;
    logic [ROW_W-1:0] r_row_addr;
    logic             r_row_addr_vld;
    logic             r_row_wr_en;
    logic [ROW_W:0]   r_row_cnt;
    logic [ROW_W-1:0] r_expected;
    logic             r_clr_done;
    logic             r_clr_ok;
    logic             r_err_proto;
    logic             r_err_seq;
    logic             r_err_len;

    logic w_entry;
    logic w_gate_err;
    logic w_both;
    logic w_split;
    logic w_proto_set;
    logic w_seq_set;
    logic w_len_set;
    logic w_proto_nxt;
    logic w_seq_nxt;
    logic w_len_nxt;

    assign w_entry    = (r_state == IDLE) && !w_lrn;
    assign w_gate_err = (r_state != IDLE) && (w_g1 || w_col_start || w_col_shift);
    assign w_both     = w_ren && w_woe;
    assign w_split    = w_ren ^ w_woe;

    // Error conditions detected on the current sample
    always_comb begin
        w_proto_set = w_gate_err;
        w_seq_set   = 1'b0;
        w_len_set   = 1'b0;
        if (w_lrn) begin
            // Pass ended while a strobe was in flight: that row is short
            if (r_state == WRITE) begin
                w_len_set = 1'b1;
            end
        end else begin
            case (r_state)
                SHIFT: begin
                    if (w_ren || w_woe) begin
                        w_proto_set = 1'b1;
                    end
                    if (w_g2 && (r_smp_cnt < SMP_MAX)) begin
                        w_len_set = 1'b1;
                    end
                end
                LATCHED: begin
                    if (w_g2 || w_split) begin
                        w_proto_set = 1'b1;
                    end
                end
                WRITE: begin
                    if (w_split) begin
                        w_proto_set = 1'b1;
                    end else if (!w_both) begin
                        if (r_stb_cnt != STB_REQ) begin
                            w_len_set = 1'b1;
                        end
                        if (r_row_addr != r_expected) begin
                            w_seq_set = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign w_proto_nxt = r_err_proto || w_proto_set;
    assign w_seq_nxt   = r_err_seq   || w_seq_set;
    assign w_len_nxt   = r_err_len   || w_len_set;

    // Sticky error flags, cleared only by reset or the start of a new pass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_proto <= 1'b0;
            r_err_seq   <= 1'b0;
            r_err_len   <= 1'b0;
        end else if (w_entry) begin
            r_err_proto <= 1'b0;
            r_err_seq   <= 1'b0;
            r_err_len   <= 1'b0;
        end else begin
            r_err_proto <= w_proto_nxt;
            r_err_seq   <= w_seq_nxt;
            r_err_len   <= w_len_nxt;
        end
    end

    // Receiver FSM: deserialize, latch, decode write strobe, track pass progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_shift        <= '0;
            r_smp_cnt      <= '0;
            r_stb_cnt      <= '0;
            r_row_addr     <= '0;
            r_row_addr_vld <= 1'b0;
            r_row_wr_en    <= 1'b0;
            r_row_cnt      <= '0;
            r_expected     <= '0;
            r_clr_done     <= 1'b0;
            r_clr_ok       <= 1'b0;
        end else begin
            r_row_addr_vld <= 1'b0;
            r_clr_done     <= 1'b0;
            if (r_state == IDLE) begin
                r_row_wr_en <= 1'b0;
                if (!w_lrn) begin
                    r_state    <= SHIFT;
                    r_row_cnt  <= '0;
                    r_expected <= '0;
                    r_clr_ok   <= 1'b0;
                    r_smp_cnt  <= '0;
                end
            end else if (w_lrn) begin
                // End of pass; a row still in WRITE is dropped, not counted
                r_state     <= IDLE;
                r_row_wr_en <= 1'b0;
                r_clr_done  <= 1'b1;
                r_clr_ok    <= (r_row_cnt == CNT_MAX) && !(w_proto_nxt || w_seq_nxt || w_len_nxt);
            end else begin
                case (r_state)
                    SHIFT: begin
                        if (w_g2) begin
                            r_row_addr     <= r_shift;
                            r_row_addr_vld <= 1'b1;
                            r_state        <= LATCHED;
                        end else begin
                            // LSB arrives first, so the oldest sample ends up in bit 0
                            r_shift <= {w_row_data, r_shift[ROW_W-1:1]};
                            if (r_smp_cnt != SMP_MAX) begin
                                r_smp_cnt <= r_smp_cnt + 1'b1;
                            end
                        end
                    end
                    LATCHED: begin
                        if (w_both) begin
                            r_state     <= WRITE;
                            r_stb_cnt   <= STB_W'(1);
                            r_row_wr_en <= 1'b1;
                        end
                    end
                    WRITE: begin
                        r_row_wr_en <= w_both;
                        if (w_both) begin
                            if (r_stb_cnt != STB_MAX) begin
                                r_stb_cnt <= r_stb_cnt + 1'b1;
                            end
                        end else if (!w_split) begin
                            if (r_row_cnt != CNT_MAX) begin
                                r_row_cnt <= r_row_cnt + 1'b1;
                            end
                            r_expected <= ROW_W'(next_row(32'(r_expected), NUM_ROWS));
                            r_smp_cnt  <= '0;
                            r_state    <= SHIFT;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign row_addr     = r_row_addr;
    assign row_addr_vld = r_row_addr_vld;
    assign row_wr_en    = r_row_wr_en;
    assign row_cnt      = r_row_cnt;
    assign clr_done     = r_clr_done;
    assign clr_ok       = r_clr_ok;
    assign err_proto    = r_err_proto;
    assign err_seq      = r_err_seq;
    assign err_len      = r_err_len;

endmodule

// File: tb/tb_scan_row_rx.sv
// tb_scan_row_rx: randomized and directed stimulus for scan_row_rx against a pass-level model.
// Latency: expects registered outputs one cycle after each sample (default build).
// Backpressure: n/a; the bench drives one link sample per clock.
module tb_scan_row_rx;
    import scan_pkg::*;

    localparam int RW = SCAN_ROW_W;
    localparam int NR = SCAN_NUM_ROWS;
    localparam int SL = SCAN_STROBE_LEN;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          lrn       = 1'b1;
    logic          g2        = 1'b0;
    logic          ren       = 1'b0;
    logic          woe       = 1'b0;
    logic          g1        = 1'b0;
    logic          col_start = 1'b0;
    logic          col_shift = 1'b0;
    logic          row_data  = 1'b0;
    logic [RW-1:0] row_addr;
    logic          row_addr_vld;
    logic          row_wr_en;
    logic [RW:0]   row_cnt;
    logic          clr_done;
    logic          clr_ok;
    logic          err_proto;
    logic          err_seq;
    logic          err_len;

    always #5 clk = ~clk;

    scan_row_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lrn          (lrn),
        .g2           (g2),
        .ren          (ren),
        .woe          (woe),
        .g1           (g1),
        .col_start    (col_start),
        .col_shift    (col_shift),
        .row_data     (row_data),
        .row_addr     (row_addr),
        .row_addr_vld (row_addr_vld),
        .row_wr_en    (row_wr_en),
        .row_cnt      (row_cnt),
        .clr_done     (clr_done),
        .clr_ok       (clr_ok),
        .err_proto    (err_proto),
        .err_seq      (err_seq),
        .err_len      (err_len)
    );

    int n_vec = 0;
    int n_err = 0;

    // Pass-level reference model: serial bit history plus per-pass tallies
    bit hist[$];
    int m_rows, m_exp_row, m_wr, m_vld;
    bit m_len, m_seq, m_proto;
    int o_wr, o_vld, o_done;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < RW; i++) hist.push_back(1'b0);
    endtask

    // Drive one sample, then observe the registered response at the next falling edge
    task automatic smp(input bit l, input bit g, input bit r, input bit w, input bit d, input bit gate);
        lrn = l; g2 = g; ren = r; woe = w; row_data = d; g1 = gate;
        col_start = 1'b0; col_shift = 1'b0;
        @(negedge clk);
        if (row_wr_en)    o_wr++;
        if (row_addr_vld) o_vld++;
        if (clr_done)     o_done++;
    endtask

    task automatic begin_pass();
        smp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        m_rows = 0; m_exp_row = 0; m_wr = 0; m_vld = 0;
        m_len = 1'b0; m_seq = 1'b0; m_proto = 1'b0;
        o_wr = 0; o_vld = 0; o_done = 0;
    endtask

    // glitch: 0 none, 1 ren during first bit, 2 g1 during first bit, 3 woe-only after g2
    // mode: 0 complete row, 1 stop inside strobe for an lrn abort, 2 stop inside strobe
    task automatic send_row(input int addr, input int nbits, input int stb, input int glitch, input int mode);
        bit            bits[$];
        logic [RW-1:0] exp_addr;
        int            nlead, naddr;
        nlead = (nbits > RW) ? nbits - RW : 0;
        naddr = (nbits < RW) ? nbits : RW;
        for (int i = 0; i < nlead; i++) bits.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < naddr; i++) bits.push_back(1'((addr >> i) & 1));
        foreach (bits[i]) begin
            smp(1'b0, 1'b0, (glitch == 1 && i == 0), 1'b0, bits[i], (glitch == 2 && i == 0));
            hist.push_back(bits[i]);
            if (hist.size() > RW) void'(hist.pop_front());
        end
        if (glitch != 0) m_proto = 1'b1;
        if (nbits < RW)  m_len = 1'b1;
        for (int i = 0; i < RW; i++) exp_addr[i] = hist[i];
        smp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        m_vld++;
        n_vec++;
        if (row_addr_vld !== 1'b1 || row_addr !== exp_addr) begin
            n_err++;
            $display("FAIL row_latch: got vld=%0b addr=%0h, want vld=1 addr=%0h", row_addr_vld, row_addr, exp_addr);
        end
        if (glitch == 3) smp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < stb; k++) smp(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        m_wr += stb;
        if (mode == 1) begin
            m_len = 1'b1;
            return;
        end
        if (mode == 2) return;
        if (stb != SL) m_len = 1'b1;
        if (int'(exp_addr) != m_exp_row) m_seq = 1'b1;
        smp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        m_rows++;
        m_exp_row = (m_exp_row + 1) % NR;
    endtask

    task automatic end_pass(input string tag);
        int        exp_cnt;
        bit        exp_ok;
        logic [RW:0] exp_cnt_v;
        exp_cnt   = (m_rows > NR) ? NR : m_rows;
        exp_cnt_v = (RW + 1)'(exp_cnt);
        exp_ok    = (exp_cnt == NR) && !(m_len || m_seq || m_proto);
        smp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (clr_done !== 1'b1) begin
            n_err++; $display("FAIL %s_clr_done: got %0b want 1", tag, clr_done);
        end
        n_vec++;
        if (clr_ok !== exp_ok) begin
            n_err++; $display("FAIL %s_clr_ok: got %0b want %0b", tag, clr_ok, exp_ok);
        end
        n_vec++;
        if (row_cnt !== exp_cnt_v) begin
            n_err++; $display("FAIL %s_row_cnt: got %0d want %0d", tag, row_cnt, exp_cnt_v);
        end
        n_vec++;
        if ({err_proto, err_seq, err_len} !== {m_proto, m_seq, m_len}) begin
            n_err++;
            $display("FAIL %s_flags: got p/s/l=%0b%0b%0b want %0b%0b%0b", tag,
                     err_proto, err_seq, err_len, m_proto, m_seq, m_len);
        end
        n_vec++;
        if (o_vld != m_vld || o_wr != m_wr) begin
            n_err++;
            $display("FAIL %s_pulses: got vld=%0d wr=%0d want vld=%0d wr=%0d", tag, o_vld, o_wr, m_vld, m_wr);
        end
        smp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (clr_done !== 1'b0) begin
            n_err++; $display("FAIL %s_clr_done_pulse: got %0b want 0", tag, clr_done);
        end
    endtask

    task automatic test_reset();
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({row_addr, row_addr_vld, row_wr_en, row_cnt, clr_done, clr_ok, err_proto, err_seq, err_len} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %0h want 0",
                {row_addr, row_addr_vld, row_wr_en, row_cnt, clr_done, clr_ok, err_proto, err_seq, err_len});
        end
        @(negedge clk);
        rst_n = 1'b1;
        smp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        smp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({row_addr_vld, row_wr_en, row_cnt, clr_done, clr_ok, err_proto, err_seq, err_len} !== '0) begin
            n_err++; $display("FAIL idle_outputs: got %0h want 0",
                {row_addr_vld, row_wr_en, row_cnt, clr_done, clr_ok, err_proto, err_seq, err_len});
        end
    endtask

    task automatic test_full_pass();
        begin_pass();
        for (int r = 0; r < NR; r++) send_row(r, RW, SL, 0, 0);
        n_vec++;
        if (o_vld != 1024 || o_wr != 3072) begin
            n_err++; $display("FAIL full_counts: got vld=%0d wr=%0d want 1024 3072", o_vld, o_wr);
        end
        end_pass("full");
    endtask

    task automatic test_addr_2a5();
        begin_pass();
        send_row(32'h2A5, RW, SL, 0, 0);
        n_vec++;
        if (row_addr !== 10'h2A5 || err_seq !== 1'b1) begin
            n_err++; $display("FAIL addr_2a5: got addr=%0h seq=%0b want 2a5 1", row_addr, err_seq);
        end
        end_pass("addr2a5");
    endtask

    task automatic test_seq_err();
        begin_pass();
        for (int r = 0; r < 4; r++) send_row(r, RW, SL, 0, 0);
        n_vec++;
        if (err_seq !== 1'b0) begin
            n_err++; $display("FAIL seq_before: got %0b want 0", err_seq);
        end
        send_row(5, RW, SL, 0, 0);
        n_vec++;
        if (err_seq !== 1'b1) begin
            n_err++; $display("FAIL seq_after: got %0b want 1", err_seq);
        end
        end_pass("seq");
    endtask

    task automatic test_len_err();
        begin_pass();
        send_row(0, RW, 2, 0, 0);
        n_vec++;
        if (err_len !== 1'b1) begin
            n_err++; $display("FAIL len_strobe2: got %0b want 1", err_len);
        end
        end_pass("len_stb");
        begin_pass();
        send_row(0, 7, SL, 0, 0);
        n_vec++;
        if (err_len !== 1'b1) begin
            n_err++; $display("FAIL len_bits7: got %0b want 1", err_len);
        end
        end_pass("len_bits");
    endtask

    task automatic test_proto();
        begin_pass();
        send_row(0, RW, SL, 0, 0);
        smp(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        hist.push_back(1'b0);
        void'(hist.pop_front());
        m_proto = 1'b1;
        n_vec++;
        if (err_proto !== 1'b1) begin
            n_err++; $display("FAIL proto_no_g2: got %0b want 1", err_proto);
        end
        end_pass("proto_no_g2");
        begin_pass();
        send_row(0, RW, SL, 3, 0);
        n_vec++;
        if (err_proto !== 1'b1) begin
            n_err++; $display("FAIL proto_woe_only: got %0b want 1", err_proto);
        end
        end_pass("proto_woe");
        begin_pass();
        send_row(0, RW, SL, 2, 0);
        end_pass("proto_g1");
    endtask

    task automatic test_abort_write();
        begin_pass();
        send_row(0, RW, SL, 0, 0);
        send_row(1, RW, 2, 0, 1);
        end_pass("abort");
    endtask

    task automatic test_reset_mid_write();
        begin_pass();
        send_row(0, RW, SL, 0, 0);
        send_row(1, RW, 2, 0, 2);
        #2;
        rst_n = 1'b0; lrn = 1'b1; ren = 1'b0; woe = 1'b0;
        #1;
        n_vec++;
        if ({row_addr, row_addr_vld, row_wr_en, row_cnt, clr_done, clr_ok, err_proto, err_seq, err_len} !== '0) begin
            n_err++; $display("FAIL rst_mid_outputs: got %0h want 0",
                {row_addr, row_addr_vld, row_wr_en, row_cnt, clr_done, clr_ok, err_proto, err_seq, err_len});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        o_done = 0;
        for (int i = 0; i < 3; i++) smp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (o_done != 0) begin
            n_err++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", o_done);
        end
        begin_pass();
        n_vec++;
        if (row_cnt !== '0 || {err_proto, err_seq, err_len} !== 3'b000) begin
            n_err++; $display("FAIL rst_mid_restart: got cnt=%0d flags=%0b want 0 000",
                              row_cnt, {err_proto, err_seq, err_len});
        end
        send_row(0, RW, SL, 0, 0);
        end_pass("rst_restart");
    endtask

    task automatic test_random();
        int nrows, addr, nbits, stb, glitch;
        for (int p = 0; p < 3; p++) begin
            begin_pass();
            nrows = $urandom_range(20, 40);
            for (int r = 0; r < nrows; r++) begin
                addr   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, NR - 1) : m_exp_row;
                nbits  = ($urandom_range(0, 9) == 0) ? $urandom_range(7, 12) : RW;
                stb    = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 5) : SL;
                glitch = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
                send_row(addr, nbits, stb, glitch, 0);
            end
            end_pass("random");
        end
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_addr_2a5();
        test_seq_err();
        test_len_err();
        test_proto();
        test_abort_write();
        test_reset_mid_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
